// File: rtl/ex_cond_stage.sv
// Execute-stage back end: folds ALU flags into set/branch results and registers
// the outcome with its controls into the EX/MEM boundary (stall holds, flush bubbles).
module ex_cond_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_neg,
  input  logic         alu_ofl,
  input  logic         alu_carry,
  input  logic [3:0]   cond_op,
  input  logic         in_valid,
  input  logic [2:0]   in_wr_reg,
  input  logic         in_wr_en,
  input  logic         in_mem_rd,
  input  logic         in_mem_wr,
  input  logic [N-1:0] in_store_data,
  input  logic         stall,
  input  logic         flush,
  output logic         branch_taken,
  output logic         ex_valid,
  output logic         ex_wr_en,
  output logic         ex_mem_rd,
  output logic         ex_mem_wr,
  output logic [N-1:0] ex_result,
  output logic [2:0]   ex_wr_reg,
  output logic [N-1:0] ex_store_data,
  output logic         ex_branch_taken,
  output logic         ex_err
);

  typedef enum logic [3:0] {
    OP_PASS = 4'd0, OP_SEQ  = 4'd1, OP_SLT  = 4'd2, OP_SLE = 4'd3,
    OP_SCO  = 4'd4, OP_BEQZ = 4'd5, OP_BNEZ = 4'd6, OP_BLTZ = 4'd7,
    OP_BGEZ = 4'd8
  } cond_op_e;

  typedef struct packed {
    logic         valid;
    logic         wr_en;
    logic         mem_rd;
    logic         mem_wr;
    logic         br_taken;
    logic         err;
    logic [N-1:0] result;
    logic [2:0]   wr_reg;
    logic [N-1:0] store_data;
  } ex_reg_t;

  // Signed A<B from A + ~B + 1; overflow flips the sign bit's meaning.
  logic less;
  assign less = alu_neg ^ alu_ofl;

  logic [N-1:0] result;
  logic         taken, is_br, illegal, mem_conflict;

  always_comb begin
    result  = alu_out;
    taken   = 1'b0;
    is_br   = 1'b0;
    illegal = 1'b0;
    case (cond_op)
      OP_PASS: result = alu_out;
      OP_SEQ:  result = {{(N-1){1'b0}}, alu_zero};
      OP_SLT:  result = {{(N-1){1'b0}}, less};
      OP_SLE:  result = {{(N-1){1'b0}}, less | alu_zero};
      OP_SCO:  result = {{(N-1){1'b0}}, alu_carry};
      OP_BEQZ: begin is_br = 1'b1; taken = alu_zero;  end
      OP_BNEZ: begin is_br = 1'b1; taken = ~alu_zero; end
      OP_BLTZ: begin is_br = 1'b1; taken = alu_neg;   end
      OP_BGEZ: begin is_br = 1'b1; taken = ~alu_neg;  end
      default: illegal = 1'b1;
    endcase
  end

  assign mem_conflict = in_mem_rd & in_mem_wr;
  assign branch_taken = taken & in_valid & ~flush;

  ex_reg_t nxt, q;

  always_comb begin
    nxt            = '0;
    nxt.result     = result;
    nxt.wr_reg     = in_wr_reg;
    nxt.store_data = in_store_data;
    if (in_valid && !flush) begin
      nxt.valid    = 1'b1;
      nxt.br_taken = taken;
      nxt.err      = illegal | mem_conflict;
      // Branches and illegal ops must not touch the register file or memory.
      nxt.wr_en    = in_wr_en & ~is_br & ~illegal;
      nxt.mem_rd   = in_mem_rd & ~is_br & ~illegal & ~mem_conflict;
      nxt.mem_wr   = in_mem_wr & ~is_br & ~illegal & ~mem_conflict;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (!stall) q <= nxt;
  end

  assign ex_valid        = q.valid;
  assign ex_wr_en        = q.wr_en;
  assign ex_mem_rd       = q.mem_rd;
  assign ex_mem_wr       = q.mem_wr;
  assign ex_branch_taken = q.br_taken;
  assign ex_err          = q.err;
  assign ex_result       = q.result;
  assign ex_wr_reg       = q.wr_reg;
  assign ex_store_data   = q.store_data;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Scoreboard bench for ex_cond_stage: driver pushes hand-computed expectations,
// a monitor pops one per clock edge and compares the registered outputs.
module tb_ex_cond_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] alu_out = '0;
  logic        alu_zero = 0, alu_neg = 0, alu_ofl = 0, alu_carry = 0;
  logic [3:0]  cond_op = '0;
  logic        in_valid = 0, in_wr_en = 0, in_mem_rd = 0, in_mem_wr = 0;
  logic [2:0]  in_wr_reg = '0;
  logic [15:0] in_store_data = '0;
  logic        stall = 0, flush = 0;
  logic        branch_taken, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr;
  logic        ex_branch_taken, ex_err;
  logic [15:0] ex_result, ex_store_data;
  logic [2:0]  ex_wr_reg;

  ex_cond_stage #(.N(16)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_ofl(alu_ofl), .alu_carry(alu_carry), .cond_op(cond_op), .in_valid(in_valid),
    .in_wr_reg(in_wr_reg), .in_wr_en(in_wr_en), .in_mem_rd(in_mem_rd),
    .in_mem_wr(in_mem_wr), .in_store_data(in_store_data), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_result(ex_result),
    .ex_wr_reg(ex_wr_reg), .ex_store_data(ex_store_data),
    .ex_branch_taken(ex_branch_taken), .ex_err(ex_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v, we, mr, mw, bt, er;
    logic [15:0] res;
    logic [2:0]  wr;
    logic [15:0] sd;
    logic        chkd;   // data fields are don't-care for bubbles
  } exp_t;

  exp_t q[$];
  int errs = 0, checks = 0;

  function automatic exp_t mk(input logic v, we, mr, mw, bt, er, input logic [15:0] res,
                              input logic [2:0] wr, input logic [15:0] sd, input logic chkd);
    exp_t e;
    e = '{v:v, we:we, mr:mr, mw:mw, bt:bt, er:er, res:res, wr:wr, sd:sd, chkd:chkd};
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(0, 0, 0, 0, 0, 0, 16'h0, 3'd0, 16'h0, 1'b0);
  endfunction

  task automatic cyc(input string nm, input logic [3:0] op, input logic [15:0] ao,
                     input logic z, n, o, c, input logic v, we, mr, mw,
                     input logic [2:0] wr, input logic [15:0] sd, input logic st, fl,
                     input logic ebt, input exp_t e);
    @(negedge clk);
    cond_op = op; alu_out = ao; alu_zero = z; alu_neg = n; alu_ofl = o; alu_carry = c;
    in_valid = v; in_wr_en = we; in_mem_rd = mr; in_mem_wr = mw;
    in_wr_reg = wr; in_store_data = sd; stall = st; flush = fl;
    q.push_back(e);
    #1;
    checks++;
    if (branch_taken !== ebt) begin
      errs++;
      $display("FAIL %s.branch_taken got=%b exp=%b", nm, branch_taken, ebt);
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch_taken, ex_err} !== 6'b0 ||
        ex_result !== 16'h0 || ex_wr_reg !== 3'd0 || ex_store_data !== 16'h0) begin
      errs++;
      $display("FAIL %s got v=%b we=%b mr=%b mw=%b bt=%b er=%b res=%h wr=%0d sd=%h exp all zero",
               nm, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch_taken, ex_err,
               ex_result, ex_wr_reg, ex_store_data);
    end
  endtask

  // Monitor: one registered capture per edge while expectations are pending.
  always @(posedge clk) begin
    exp_t e;
    logic bad;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      bad = {ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch_taken, ex_err} !==
            {e.v, e.we, e.mr, e.mw, e.bt, e.er};
      if (e.chkd)
        bad = bad || ex_result !== e.res || ex_wr_reg !== e.wr || ex_store_data !== e.sd;
      checks++;
      if (bad) begin
        errs++;
        $display("FAIL capture#%0d got v=%b we=%b mr=%b mw=%b bt=%b er=%b res=%h wr=%0d sd=%h exp v=%b we=%b mr=%b mw=%b bt=%b er=%b res=%h wr=%0d sd=%h",
                 checks, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch_taken, ex_err,
                 ex_result, ex_wr_reg, ex_store_data,
                 e.v, e.we, e.mr, e.mw, e.bt, e.er, e.res, e.wr, e.sd);
      end
    end
  end

  initial begin
    // Reset state
    #3; chk_zero("reset");
    @(negedge clk); rst = 1'b0;

    cyc("pass_aa", 4'd0, 16'h00AA, 0,0,0,0, 1,1,0,0, 3'd5, 16'hBEEF, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h00AA, 3'd5, 16'hBEEF, 1));
    // Async reset mid-cycle while ex_valid=1
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst = 1'b1; #1; chk_zero("async_rst");
    @(negedge clk); rst = 1'b0; #1; chk_zero("rst_release");

    cyc("slt_ofl", 4'd2, 16'h8000, 0,1,1,0, 1,1,0,0, 3'd1, 16'h0001, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h0000, 3'd1, 16'h0001, 1));
    cyc("slt_neg", 4'd2, 16'h8000, 0,1,0,0, 1,1,0,0, 3'd2, 16'h0002, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h0001, 3'd2, 16'h0002, 1));
    cyc("sle_z",   4'd3, 16'h0000, 1,0,0,0, 1,1,0,0, 3'd3, 16'h0003, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h0001, 3'd3, 16'h0003, 1));
    cyc("seq_z",   4'd1, 16'h0000, 1,0,0,0, 1,1,0,0, 3'd4, 16'h0004, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h0001, 3'd4, 16'h0004, 1));
    cyc("sle_nz",  4'd3, 16'h0005, 0,0,0,0, 1,1,0,0, 3'd6, 16'h0006, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h0000, 3'd6, 16'h0006, 1));
    cyc("sco",     4'd4, 16'hFFFF, 0,1,0,1, 1,1,0,0, 3'd7, 16'h0007, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h0001, 3'd7, 16'h0007, 1));
    cyc("bltz",    4'd7, 16'h8001, 0,1,0,0, 1,1,0,1, 3'd5, 16'h1111, 0,0, 1,
        mk(1,0,0,0,1,0, 16'h8001, 3'd5, 16'h1111, 1));
    cyc("bgez",    4'd8, 16'h8001, 0,1,0,0, 1,1,0,0, 3'd5, 16'h2222, 0,0, 0,
        mk(1,0,0,0,0,0, 16'h8001, 3'd5, 16'h2222, 1));
    cyc("bnez",    4'd6, 16'h0042, 0,0,0,0, 1,0,0,0, 3'd0, 16'h0000, 0,0, 1,
        mk(1,0,0,0,1,0, 16'h0042, 3'd0, 16'h0000, 1));
    cyc("beqz_fl", 4'd5, 16'h0000, 1,0,0,0, 1,1,0,0, 3'd5, 16'h3333, 0,1, 0, bubble());

    // Stall hold and flush
    cyc("pass1234", 4'd0, 16'h1234, 0,0,0,0, 1,1,0,0, 3'd5, 16'hBEEF, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h1234, 3'd5, 16'hBEEF, 1));
    for (int i = 0; i < 3; i++)
      cyc("stall", 4'd0, 16'h1111 * 16'(i + 1), 0,0,0,0, 1,0,1,0, 3'd2, 16'h0F0F, 1,0, 0,
          mk(1,1,0,0,0,0, 16'h1234, 3'd5, 16'hBEEF, 1));
    cyc("flush", 4'd0, 16'h5555, 0,0,0,0, 1,1,0,0, 3'd5, 16'hBEEF, 0,1, 0, bubble());
    cyc("pass1234b", 4'd0, 16'h1234, 0,0,0,0, 1,1,0,0, 3'd5, 16'hBEEF, 0,0, 0,
        mk(1,1,0,0,0,0, 16'h1234, 3'd5, 16'hBEEF, 1));
    cyc("stall_fl", 4'd0, 16'h6666, 0,0,0,0, 1,0,0,0, 3'd1, 16'h0000, 1,1, 0,
        mk(1,1,0,0,0,0, 16'h1234, 3'd5, 16'hBEEF, 1));

    // Illegal codes and memory-control conflict
    cyc("illegal", 4'd12, 16'h0C0C, 1,1,0,1, 1,1,0,0, 3'd3, 16'h00C0, 0,0, 0,
        mk(1,0,0,0,0,1, 16'h0C0C, 3'd3, 16'h00C0, 1));
    cyc("rdwr",    4'd0, 16'h0077, 0,0,0,0, 1,0,1,1, 3'd4, 16'hA5A5, 0,0, 0,
        mk(1,0,0,0,0,1, 16'h0077, 3'd4, 16'hA5A5, 1));
    cyc("store",   4'd0, 16'h0100, 0,0,0,0, 1,0,0,1, 3'd0, 16'h5A5A, 0,0, 0,
        mk(1,0,0,1,0,0, 16'h0100, 3'd0, 16'h5A5A, 1));
    cyc("load",    4'd0, 16'h0200, 0,0,0,0, 1,1,1,0, 3'd6, 16'h0000, 0,0, 0,
        mk(1,1,1,0,0,0, 16'h0200, 3'd6, 16'h0000, 1));
    cyc("invalid", 4'd6, 16'h0300, 0,0,0,0, 0,1,1,0, 3'd6, 16'h0000, 0,0, 0, bubble());

    @(negedge clk);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
